// File: rtl/tff_bank_counter.sv
// rtl/tff_bank_counter.sv - WIDTH-bit T flip-flop bank / modulo-MOD up/down counter (optional macro TFF_SAT_EN: saturating count modes)
module tff_bank_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);

    // Reject illegal configurations at elaboration time.
    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("tff_bank_counter: WIDTH must be in 1..16");
        end
        if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
            $error("tff_bank_counter: MOD must be in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_UP     = 2'b10;
    localparam logic [1:0] MODE_DOWN   = 2'b11;

    // Highest in-range count value; also the reload value for down-count wraps.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

`ifdef TFF_SAT_EN
    // Saturating build: the count sticks at the limit and flags tc every cycle there.
    localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = LAST;
    localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = ZERO;
`else
    // Wrapping build: the count rolls over to the opposite end of the range.
    localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = ZERO;
    localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = LAST;
`endif

    // Register state and terminal-count flag: load beats enabled modes, which beat hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q  <= ZERO;
            tc <= 1'b0;
        end else if (load) begin
            q  <= d;
            tc <= 1'b0;
        end else if (!en) begin
            tc <= 1'b0;
        end else begin
            case (mode)
                MODE_HOLD: begin
                    tc <= 1'b0;
                end
                MODE_TOGGLE: begin
                    // Each set bit of t toggles its stage; no range enforcement.
                    q  <= q ^ t;
                    tc <= 1'b0;
                end
                MODE_UP: begin
                    // Values at or above LAST (e.g. loaded out of range) take the limit path.
                    if (q >= LAST) begin
                        q  <= UP_LIMIT_NEXT;
                        tc <= 1'b1;
                    end else begin
                        q  <= q + ONE;
                        tc <= 1'b0;
                    end
                end
                MODE_DOWN: begin
                    if (q == ZERO) begin
                        q  <= DOWN_LIMIT_NEXT;
                        tc <= 1'b1;
                    end else if (q > LAST) begin
                        // Out-of-range value is pulled back into range without a tc pulse.
                        q  <= LAST;
                        tc <= 1'b0;
                    end else begin
                        q  <= q - ONE;
                        tc <= 1'b0;
                    end
                end
                default: begin
                    tc <= 1'b0;
                end
            endcase
        end
    end

    // Complementary output follows q combinationally.
    assign qb = ~q;

endmodule

// File: tb/tb_tff_bank_counter.sv
// tb/tb_tff_bank_counter.sv - self-checking bench for tff_bank_counter (WIDTH=4, MOD=10), honours TFF_SAT_EN
module tb_tff_bank_counter;

    localparam int W   = 4;
    localparam int MOD = 10;
`ifdef TFF_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] t;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic         tc;

    int checks = 0;
    int errors = 0;

    // Reference state as plain integers.
    int m_q  = 0;
    int m_tc = 0;

    tff_bank_counter #(.WIDTH(W), .MOD(MOD)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .t    (t),
        .load (load),
        .d    (d),
        .q    (q),
        .qb   (qb),
        .tc   (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Next state of the reference from the current inputs, using integer arithmetic.
    task automatic model_advance();
        int nq;
        int ntc;
        nq  = m_q;
        ntc = 0;
        if (load) begin
            nq = int'(d);
        end else if (en) begin
            case (mode)
                2'b01: nq = m_q ^ int'(t);
                2'b10: begin
                    if (m_q + 1 >= MOD) begin
                        nq  = SAT ? MOD - 1 : 0;
                        ntc = 1;
                    end else begin
                        nq = m_q + 1;
                    end
                end
                2'b11: begin
                    if (m_q == 0) begin
                        nq  = SAT ? 0 : MOD - 1;
                        ntc = 1;
                    end else if (m_q >= MOD) begin
                        nq = MOD - 1;
                    end else begin
                        nq = m_q - 1;
                    end
                end
                default: nq = m_q;
            endcase
        end
        m_q  = nq;
        m_tc = ntc;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".q"},  int'(q),  m_q);
        chk({tag, ".qb"}, int'(qb), (~m_q) & ((1 << W) - 1));
        chk({tag, ".tc"}, int'(tc), m_tc);
    endtask

    // One clock edge: advance the model, sample #1 after the edge, compare.
    task automatic step(input string tag);
        model_advance();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Edge plus comparison against literal values from the test plan.
    task automatic step_lit(input string tag, input int lq, input int ltc);
        step(tag);
        chk({tag, ".lit_q"},  int'(q),  lq);
        chk({tag, ".lit_tc"}, int'(tc), ltc);
    endtask

    task automatic set_in(input logic l, input logic [W-1:0] dv, input logic e,
                          input logic [1:0] m, input logic [W-1:0] tv);
        load = l; d = dv; en = e; mode = m; t = tv;
    endtask

    initial begin
        rst = 1'b0;
        set_in(1'b0, '0, 1'b0, 2'b00, '0);

        // Reset state while rst is low.
        #12;
        check_outputs("reset_init");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("post_reset_idle");

        // Asynchronous reset mid-cycle from q=7.
        set_in(1'b1, 4'd7, 1'b0, 2'b00, '0);
        step_lit("load7", 7, 0);
        set_in(1'b0, '0, 1'b1, 2'b10, '0);
        #3;
        rst = 1'b0;
        #1;
        m_q = 0; m_tc = 0;
        check_outputs("async_reset");
        @(posedge clk);
        #1;
        check_outputs("reset_held");
        rst = 1'b1;
        set_in(1'b0, '0, 1'b0, 2'b10, '0);
        step_lit("after_release", 0, 0);

        // Toggle by mask.
        set_in(1'b0, '0, 1'b1, 2'b01, 4'b1010);
        step_lit("toggle1", 10, 0);
        step_lit("toggle2", 0, 0);

        // Up wrap (or saturation) from 8.
        set_in(1'b1, 4'd8, 1'b0, 2'b00, '0);
        step_lit("load8", 8, 0);
        set_in(1'b0, '0, 1'b1, 2'b10, '0);
        step_lit("up1", 9, 0);
        step_lit("up2", SAT ? 9 : 0, 1);
        step_lit("up3", SAT ? 9 : 1, SAT ? 1 : 0);

        // Down from out-of-range and from zero.
        set_in(1'b1, 4'd13, 1'b0, 2'b00, '0);
        step_lit("load13", 13, 0);
        set_in(1'b0, '0, 1'b1, 2'b11, '0);
        step_lit("down_oor", 9, 0);
        set_in(1'b1, 4'd0, 1'b0, 2'b00, '0);
        step_lit("load0", 0, 0);
        set_in(1'b0, '0, 1'b1, 2'b11, '0);
        step_lit("down_zero", SAT ? 0 : 9, 1);

        // Load priority over counting, then enable-low hold.
        set_in(1'b1, 4'd2, 1'b0, 2'b00, '0);
        step_lit("load2", 2, 0);
        set_in(1'b1, 4'd5, 1'b1, 2'b10, '0);
        step_lit("prio_load", 5, 0);
        set_in(1'b0, '0, 1'b0, 2'b10, '0);
        step_lit("en_low_hold", 5, 0);

        // Enable gating from 0.
        set_in(1'b1, 4'd0, 1'b0, 2'b00, '0);
        step_lit("load0b", 0, 0);
        set_in(1'b0, '0, 1'b1, 2'b10, '0);
        step_lit("gate1", 1, 0);
        en = 1'b0;
        step_lit("gate2", 1, 0);
        en = 1'b1;
        step_lit("gate3", 2, 0);
        en = 1'b0;
        step_lit("gate4", 2, 0);
        en = 1'b1;
        step_lit("gate5", 3, 0);

        // Randomised traffic against the reference, with occasional async resets.
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 7) == 0);
            d    = W'($urandom);
            en   = ($urandom_range(0, 3) != 0);
            mode = 2'($urandom);
            t    = W'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                m_q = 0; m_tc = 0;
                check_outputs("rand_reset");
                #2;
                rst = 1'b1;
            end
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
